// File: rtl/ahb2apb_bridge_param.sv
// AHB-Lite to APB bridge: one transfer at a time, slot decoded from an HADDR field, all outputs registered.
// Define BRIDGE_TIMEOUT_EN to build the ACCESS-phase timeout counter (limit set by TIMEOUT).
module ahb2apb_bridge_param #(
    parameter int ADDR_W    = 32,
    parameter int NUM_SLOTS = 16,
    parameter int SLOT_LSB  = 24,
    parameter int TIMEOUT   = 255
) (
    input  logic                 HCLK,
    input  logic                 HRESETN,
    input  logic                 HSEL,
    input  logic [ADDR_W-1:0]    HADDR,
    input  logic                 HWRITE,
    input  logic [1:0]           HTRANS,
    input  logic [31:0]          HWDATA,
    input  logic                 HREADYIN,
    output logic                 HREADYOUT,
    output logic [31:0]          HRDATA,
    output logic                 HRESP,
    output logic [NUM_SLOTS-1:0] PSEL,
    output logic [ADDR_W-1:0]    PADDR,
    output logic                 PWRITE,
    output logic                 PENABLE,
    output logic [31:0]          PWDATA,
    input  logic [31:0]          PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR
);
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [SLOT_W:0] NUM_SLOTS_V = NUM_SLOTS[SLOT_W:0];

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WDATA  = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3,
        ERR1   = 3'd4,
        ERR2   = 3'd5
    } state_t;

    state_t                state_r, state_s;
    logic [NUM_SLOTS-1:0]  sel_r, sel_s;
    logic [NUM_SLOTS-1:0]  psel_r, psel_s;
    logic                  penable_r, penable_s;
    logic [ADDR_W-1:0]     paddr_r, paddr_s;
    logic                  pwrite_r, pwrite_s;
    logic [31:0]           pwdata_r, pwdata_s;
    logic                  hready_r, hready_s;
    logic                  hresp_r, hresp_s;
    logic [31:0]           hrdata_r, hrdata_s;

    logic                  accept_s;
    logic [SLOT_W-1:0]     slot_idx_s;
    logic                  slot_ok_s;
    logic [NUM_SLOTS-1:0]  slot_dec_s;

`ifdef BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
    logic [15:0] tmo_cnt_r, tmo_cnt_s;
`endif

    // NONSEQ and SEQ are the only transfer types that start an APB access.
    assign accept_s   = HSEL & HREADYIN & ((HTRANS == 2'b10) | (HTRANS == 2'b11));
    assign slot_idx_s = HADDR[SLOT_LSB +: SLOT_W];
    assign slot_ok_s  = ({1'b0, slot_idx_s} < NUM_SLOTS_V);
    assign slot_dec_s = NUM_SLOTS'(1'b1) << slot_idx_s;

    // Next-state and next-output decode for the bridge FSM.
    always_comb begin
        state_s   = state_r;
        sel_s     = sel_r;
        psel_s    = {NUM_SLOTS{1'b0}};
        penable_s = 1'b0;
        paddr_s   = paddr_r;
        pwrite_s  = pwrite_r;
        pwdata_s  = pwdata_r;
        hready_s  = 1'b1;
        hresp_s   = 1'b0;
        hrdata_s  = hrdata_r;
`ifdef BRIDGE_TIMEOUT_EN
        tmo_cnt_s = tmo_cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    paddr_s  = HADDR;
                    pwrite_s = HWRITE;
                    sel_s    = slot_dec_s;
                    hready_s = 1'b0;
                    if (!slot_ok_s) begin
                        state_s = ERR1;
                        hresp_s = 1'b1;
                    end else if (HWRITE) begin
                        state_s = WDATA;
                    end else begin
                        state_s = SETUP;
                        psel_s  = slot_dec_s;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WDATA: begin
                pwdata_s = HWDATA;
                state_s  = SETUP;
                psel_s   = sel_r;
                hready_s = 1'b0;
            end
            SETUP: begin
                state_s   = ACCESS;
                psel_s    = psel_r;
                penable_s = 1'b1;
                hready_s  = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
                tmo_cnt_s = 16'd0;
`endif
            end
            ACCESS: begin
                if (PREADY) begin
                    if (PSLVERR) begin
                        state_s  = ERR1;
                        hready_s = 1'b0;
                        hresp_s  = 1'b1;
                    end else begin
                        state_s = IDLE;
                        if (!pwrite_r) begin
                            hrdata_s = PRDATA;
                        end else begin
                            hrdata_s = hrdata_r;
                        end
                    end
                end else begin
`ifdef BRIDGE_TIMEOUT_EN
                    if (tmo_cnt_r == TIMEOUT_LAST) begin
                        state_s  = ERR1;
                        hready_s = 1'b0;
                        hresp_s  = 1'b1;
                    end else begin
                        tmo_cnt_s = tmo_cnt_r + 16'd1;
                        state_s   = ACCESS;
                        psel_s    = psel_r;
                        penable_s = 1'b1;
                        hready_s  = 1'b0;
                    end
`else
                    state_s   = ACCESS;
                    psel_s    = psel_r;
                    penable_s = 1'b1;
                    hready_s  = 1'b0;
`endif
                end
            end
            ERR1: begin
                state_s = ERR2;
                hresp_s = 1'b1;
            end
            ERR2: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            state_r   <= IDLE;
            sel_r     <= {NUM_SLOTS{1'b0}};
            psel_r    <= {NUM_SLOTS{1'b0}};
            penable_r <= 1'b0;
            paddr_r   <= {ADDR_W{1'b0}};
            pwrite_r  <= 1'b0;
            pwdata_r  <= 32'd0;
            hready_r  <= 1'b1;
            hresp_r   <= 1'b0;
            hrdata_r  <= 32'd0;
        end else begin
            state_r   <= state_s;
            sel_r     <= sel_s;
            psel_r    <= psel_s;
            penable_r <= penable_s;
            paddr_r   <= paddr_s;
            pwrite_r  <= pwrite_s;
            pwdata_r  <= pwdata_s;
            hready_r  <= hready_s;
            hresp_r   <= hresp_s;
            hrdata_r  <= hrdata_s;
        end
    end

`ifdef BRIDGE_TIMEOUT_EN
    // Counts ACCESS cycles spent waiting on PREADY.
    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            tmo_cnt_r <= 16'd0;
        end else begin
            tmo_cnt_r <= tmo_cnt_s;
        end
    end
`endif

    assign HREADYOUT = hready_r;
    assign HRESP     = hresp_r;
    assign HRDATA    = hrdata_r;
    assign PSEL      = psel_r;
    assign PENABLE   = penable_r;
    assign PADDR     = paddr_r;
    assign PWRITE    = pwrite_r;
    assign PWDATA    = pwdata_r;

endmodule

// File: tb/tb_ahb2apb_bridge_param.sv
// Self-checking bench for ahb2apb_bridge_param: a transfer-level timeline model predicts every output cycle.
module tb_ahb2apb_bridge_param;
    localparam int AW = 32;
    localparam int NS = 10;
    localparam int TO = 8;

    logic           HCLK = 1'b0;
    logic           HRESETN, HSEL, HWRITE, HREADYIN, PREADY, PSLVERR;
    logic [AW-1:0]  HADDR;
    logic [1:0]     HTRANS;
    logic [31:0]    HWDATA, PRDATA;
    logic           HREADYOUT, HRESP, PWRITE, PENABLE;
    logic [31:0]    HRDATA, PWDATA;
    logic [NS-1:0]  PSEL;
    logic [AW-1:0]  PADDR;

    always #5 HCLK = ~HCLK;

    ahb2apb_bridge_param #(
        .ADDR_W(AW), .NUM_SLOTS(NS), .SLOT_LSB(24), .TIMEOUT(TO)
    ) dut (
        .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HTRANS(HTRANS), .HWDATA(HWDATA), .HREADYIN(HREADYIN), .HREADYOUT(HREADYOUT),
        .HRDATA(HRDATA), .HRESP(HRESP), .PSEL(PSEL), .PADDR(PADDR), .PWRITE(PWRITE),
        .PENABLE(PENABLE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    int n_chk = 0;
    int n_pass = 0;

    // model expectations for the current cycle
    logic           e_hready, e_hresp, e_penable, e_hrdata_v, e_all;
    logic [NS-1:0]  e_psel;
    logic [31:0]    m_paddr, m_pwdata, m_hrdata;
    logic           m_pwrite;

    int             obs_waits, obs_pen;
    logic [NS-1:0]  obs_psel;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic set_exp(input logic hr, input logic hs, input logic [NS-1:0] ps, input logic pe);
        e_hready = hr; e_hresp = hs; e_psel = ps; e_penable = pe;
    endtask

    task automatic compare();
        chk("HREADYOUT", 32'(HREADYOUT), 32'(e_hready));
        chk("HRESP", 32'(HRESP), 32'(e_hresp));
        chk("PSEL", 32'(PSEL), 32'(e_psel));
        chk("PENABLE", 32'(PENABLE), 32'(e_penable));
        chk("PSEL_onehot0", 32'($onehot0(PSEL)), 32'd1);
        if (e_psel != '0 || e_all) begin
            chk("PADDR", PADDR, m_paddr);
            chk("PWRITE", 32'(PWRITE), 32'(m_pwrite));
        end
        if ((e_psel != '0 && m_pwrite) || e_all) chk("PWDATA", PWDATA, m_pwdata);
        if (e_hrdata_v || e_all) chk("HRDATA", HRDATA, m_hrdata);
    endtask

    // compare at the falling edge, then advance past the next rising edge
    task automatic cycle();
        @(negedge HCLK);
        compare();
        if (!HREADYOUT) obs_waits++;
        if (PENABLE) obs_pen++;
        obs_psel = obs_psel | PSEL;
        @(posedge HCLK);
        #1;
        e_hrdata_v = 1'b0;
        e_all = 1'b0;
    endtask

    task automatic idle_bus();
        HTRANS = 2'b00; HSEL = 1'($urandom_range(0, 1)); HADDR = $urandom;
        HWRITE = 1'($urandom_range(0, 1)); HREADYIN = 1'b1;
    endtask

    // Entered in a cycle where HREADYOUT must be 1; returns in the next such cycle.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int nwait, input logic err, input logic [31:0] rd);
        int            slot;
        int            n_acc;
        logic          tmo;
        logic [NS-1:0] oh;
        slot = int'(addr[27:24]);
        obs_waits = 0; obs_pen = 0; obs_psel = '0;
        HSEL = 1'b1; HTRANS = 2'b10; HREADYIN = 1'b1; HADDR = addr; HWRITE = wr; HWDATA = $urandom;
        cycle();
        idle_bus();
        if (slot >= NS) begin
            set_exp(1'b0, 1'b1, '0, 1'b0); cycle();
            set_exp(1'b1, 1'b1, '0, 1'b0); cycle();
            set_exp(1'b1, 1'b0, '0, 1'b0);
            return;
        end
        oh = NS'(1) << slot;
        m_paddr = addr; m_pwrite = wr;
        if (wr) begin
            set_exp(1'b0, 1'b0, '0, 1'b0);
            HWDATA = wd;
            cycle();
            HWDATA = $urandom;
            m_pwdata = wd;
        end
        set_exp(1'b0, 1'b0, oh, 1'b0);
        cycle();
        n_acc = nwait + 1;
        tmo = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
        if (nwait >= TO) begin
            n_acc = TO;
            tmo = 1'b1;
        end
`endif
        for (int i = 0; i < n_acc; i++) begin
            set_exp(1'b0, 1'b0, oh, 1'b1);
            PREADY = (!tmo && i == n_acc - 1);
            PSLVERR = PREADY ? err : 1'($urandom_range(0, 1));
            PRDATA = PREADY ? rd : $urandom;
            cycle();
        end
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
        if (err || tmo) begin
            set_exp(1'b0, 1'b1, '0, 1'b0); cycle();
            set_exp(1'b1, 1'b1, '0, 1'b0); cycle();
            set_exp(1'b1, 1'b0, '0, 1'b0);
        end else begin
            set_exp(1'b1, 1'b0, '0, 1'b0);
            if (!wr) begin
                m_hrdata = rd;
                e_hrdata_v = 1'b1;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0: begin HSEL = 1'b0; HTRANS = 2'b10; HREADYIN = 1'b1; end
                1: begin HSEL = 1'b1; HTRANS = 2'b00; HREADYIN = 1'b1; end
                2: begin HSEL = 1'b1; HTRANS = 2'b01; HREADYIN = 1'b1; end
                default: begin HSEL = 1'b1; HTRANS = 2'b10; HREADYIN = 1'b0; end
            endcase
            HADDR = $urandom;
            set_exp(1'b1, 1'b0, '0, 1'b0);
            cycle();
        end
        idle_bus();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        HRESETN = 1'b0; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HTRANS = 2'b00; HWDATA = '0;
        HREADYIN = 1'b1; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        e_hrdata_v = 1'b0; e_all = 1'b0;
        obs_waits = 0; obs_pen = 0; obs_psel = '0;
        repeat (2) @(posedge HCLK);
        #1;
        set_exp(1'b1, 1'b0, '0, 1'b0);
        m_paddr = '0; m_pwdata = '0; m_pwrite = 1'b0; m_hrdata = '0; e_all = 1'b1;
        HRESETN = 1'b1;

        // read slot 3, accepted in the first cycle out of reset
        xfer(1'b0, 32'h0300_0010, 32'h0, 0, 1'b0, 32'hDEADBEEF);
        chk("rd_psel", 32'(obs_psel), 32'h0000_0008);
        chk("rd_waits", 32'(obs_waits), 32'd2);
        chk("rd_hrdata", HRDATA, 32'hDEADBEEF);
        chk("rd_hresp", 32'(HRESP), 32'd0);

        // back-to-back write with 4 PREADY-low cycles
        xfer(1'b1, 32'h0500_0004, 32'h1234_5678, 4, 1'b0, 32'h0);
        chk("wr_waits", 32'(obs_waits), 32'd7);
        chk("wr_penable", 32'(obs_pen), 32'd5);

        // slave error, then decode error (slot 12 >= 10)
        xfer(1'b0, 32'h0700_0000, 32'h0, 0, 1'b1, 32'h1111_2222);
        chk("err_waits", 32'(obs_waits), 32'd3);
        xfer(1'b0, 32'h0C00_0000, 32'h0, 0, 1'b0, 32'h0);
        chk("dec_psel", 32'(obs_psel), 32'd0);
        chk("dec_waits", 32'(obs_waits), 32'd1);

        // slot boundaries: 9 is the last valid slot, 10 the first invalid
        xfer(1'b1, 32'h0900_00F0, 32'hA5A5_0F0F, 1, 1'b0, 32'h0);
        chk("slot9_psel", 32'(obs_psel), 32'h0000_0200);
        xfer(1'b1, 32'h0A00_0000, 32'h5555_AAAA, 0, 1'b0, 32'h0);
        chk("slot10_psel", 32'(obs_psel), 32'd0);

        // long PREADY-low wait: completes at ACCESS cycle 100, or times out after TO cycles
        idle_cycles(1);
        xfer(1'b0, 32'h0100_0020, 32'h0, 99, 1'b0, 32'hCAFE_F00D);
`ifdef BRIDGE_TIMEOUT_EN
        chk("tmo_penable", 32'(obs_pen), 32'(TO));
        chk("tmo_waits", 32'(obs_waits), 32'(TO + 2));
`else
        chk("long_penable", 32'(obs_pen), 32'd100);
        chk("long_hrdata", HRDATA, 32'hCAFE_F00D);
`endif

        // reset in the middle of ACCESS, then a normal read
        HSEL = 1'b1; HTRANS = 2'b10; HREADYIN = 1'b1; HADDR = 32'h0200_0008; HWRITE = 1'b0;
        cycle();
        idle_bus();
        m_paddr = 32'h0200_0008; m_pwrite = 1'b0;
        set_exp(1'b0, 1'b0, NS'(4), 1'b0); cycle();
        set_exp(1'b0, 1'b0, NS'(4), 1'b1); cycle();
        set_exp(1'b0, 1'b0, NS'(4), 1'b1); HRESETN = 1'b0; cycle();
        set_exp(1'b1, 1'b0, '0, 1'b0);
        m_paddr = '0; m_pwdata = '0; m_pwrite = 1'b0; m_hrdata = '0; e_all = 1'b1;
        HRESETN = 1'b1;
        xfer(1'b0, 32'h0200_000C, 32'h0, 1, 1'b0, 32'h5A5A_A5A5);
        chk("post_rst_hrdata", HRDATA, 32'h5A5A_A5A5);

        // randomized traffic
        for (int t = 0; t < 60; t++) begin
            a = $urandom;
            a[27:24] = 4'($urandom_range(0, 15));
            xfer(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 5)),
                 ($urandom_range(0, 7) == 0), $urandom);
            idle_cycles(int'($urandom_range(0, 2)));
        end
        idle_cycles(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
